// File: rtl/frame_stream_pkg.sv
// -----------------------------------------------------------------------------
// frame_stream_pkg
// Shared types and constants for frame_stream_player:
//   state_e      - player FSM states
//   CRC32_*      - constants for the optional per-frame FCS (FRAME_CRC_EN)
// -----------------------------------------------------------------------------
package frame_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    FCS,
    GAP,
    DONE
  } state_e;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

endpackage

// File: rtl/crc32_byte.sv
// -----------------------------------------------------------------------------
// crc32_byte
// Combinational one-byte step of the reflected CRC-32 (poly 0xEDB88320).
// Only instantiated when FRAME_CRC_EN is defined.
// Ports:
//   crc_i  [31:0] running CRC before this byte
//   data_i [7:0]  byte to absorb, least-significant bit first
//   crc_o  [31:0] running CRC after this byte
// -----------------------------------------------------------------------------
module crc32_byte
  import frame_stream_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    // NOTE: blocking assignments here are deliberate; each loop pass builds on
    // the value produced by the previous one within the same evaluation.
    crc_o = crc_i ^ {24'h00_0000, data_i};
    for (int i = 0; i < 8; i++) begin
      crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC32_POLY) : (crc_o >> 1);
    end
  end

endmodule

// File: rtl/frame_stream_player.sv
// -----------------------------------------------------------------------------
// frame_stream_player
// Replays byte frames from a loaded buffer onto a byte-wide valid/ready stream,
// with a programmable idle gap between frames and an optional repeat mode.
// Frames are packed back to back; frame k starts at sum(len[0..k-1]) mod DEPTH.
//
// Optional build macro: FRAME_CRC_EN appends a 4-byte CRC-32 FCS (LSB first)
// after every non-empty frame and moves tlast onto the last FCS byte.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   buf_we/buf_addr/buf_wdata      byte buffer load port (ignored while busy)
//   len_we/len_idx/len_wdata       frame-length table load port (ignored while busy)
//   nframes, gap, repeat_en        pass configuration, sampled on start
//   start                          pulse that begins a pass from IDLE
//   stop                           stop request, honoured at a frame boundary
//   tdata/tvalid/tready/tlast      output byte stream
//   busy                           high outside IDLE
//   done                           one-cycle pulse at the end of a run
//   frame_cnt                      frames completed since reset (wrapping)
// -----------------------------------------------------------------------------
module frame_stream_player
  import frame_stream_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int NFRAME = 16,
  parameter int LENW   = 11,
  parameter int GAPW   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      buf_we,
  input  logic [$clog2(DEPTH)-1:0]  buf_addr,
  input  logic [7:0]                buf_wdata,
  input  logic                      len_we,
  input  logic [$clog2(NFRAME)-1:0] len_idx,
  input  logic [LENW-1:0]           len_wdata,
  input  logic [$clog2(NFRAME):0]   nframes,
  input  logic [GAPW-1:0]           gap,
  input  logic                      repeat_en,
  input  logic                      start,
  input  logic                      stop,
  output logic [7:0]                tdata,
  output logic                      tvalid,
  input  logic                      tready,
  output logic                      tlast,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(NFRAME);

  // Storage
  logic [7:0]      buf_mem [DEPTH];
  logic [LENW-1:0] len_mem [NFRAME];
  logic [7:0]      rdata_q;   // RAM output register doubles as the prefetch slot
  logic            rd_en;

  // State
  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [LENW-1:0] beats_left_q, beats_left_d;
  logic [IW:0]     nframes_q, nframes_d;
  logic [GAPW-1:0] gap_q, gap_d;
  logic [GAPW-1:0] gap_cnt_q, gap_cnt_d;
  logic            repeat_q, repeat_d;
  logic            stop_pending_q, stop_pending_d;
  logic [31:0]     frame_cnt_q, frame_cnt_d;

  // Frame sequencing helpers
  logic [NFRAME-1:0] nz_mask;
  logic [IW:0]       nframes_eff;
  logic [IW:0]       next_hit, wrap_hit;
  logic              next_found, wrap_found;
  logic [IW-1:0]     next_idx, wrap_idx;
  logic [LENW-1:0]   cur_len;
  logic [AW-1:0]     base_plus_len;
  logic [AW-1:0]     adv_base, adv_addr;
  state_e            adv_state;
  logic [IW-1:0]     adv_idx;
  logic              stop_now;
  logic              frame_end;

`ifdef FRAME_CRC_EN
  logic [31:0] crc_q, crc_d, crc_next, crc_fin;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [7:0]  fcs_byte;

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (rdata_q),
    .crc_o  (crc_next)
  );

  assign crc_fin  = crc_q ^ CRC32_XOROUT;
  assign fcs_byte = 8'(crc_fin >> {fcs_idx_q, 3'b000});
`endif

  // NOTE: buffer and length table carry no reset so they map onto RAM; only
  // control state is reset.
  always_ff @(posedge clk) begin
    if (buf_we && !busy) buf_mem[buf_addr] <= buf_wdata;
    if (rd_en)           rdata_q <= buf_mem[rd_addr_q];
  end

  always_ff @(posedge clk) begin
    if (len_we && !busy) len_mem[len_idx] <= len_wdata;
  end

  // Lowest index at or above 'from' whose frame is non-empty and inside the
  // pass. Empty frames contribute no bytes, so skipping them leaves the base
  // address unchanged and costs no cycles.
  function automatic logic [IW:0] first_nz(input logic [NFRAME-1:0] mask,
                                           input logic [IW:0]       from);
    logic [IW:0] hit;
    hit = '0;
    for (int k = NFRAME - 1; k >= 0; k--) begin
      if (mask[k] && ((IW+1)'(k) >= from)) hit = {1'b1, IW'(k)};
    end
    return hit;
  endfunction

  always_comb begin
    nframes_eff = (state_q == IDLE) ? nframes : nframes_q;
    for (int k = 0; k < NFRAME; k++) begin
      nz_mask[k] = (len_mem[k] != '0) && ((IW+1)'(k) < nframes_eff);
    end
  end

  assign next_hit   = first_nz(nz_mask, (IW+1)'(idx_q) + 1'b1);
  assign wrap_hit   = first_nz(nz_mask, '0);
  assign next_found = next_hit[IW];
  assign next_idx   = next_hit[IW-1:0];
  assign wrap_found = wrap_hit[IW];
  assign wrap_idx   = wrap_hit[IW-1:0];

  assign cur_len       = len_mem[idx_q];
  assign base_plus_len = base_q + AW'(cur_len);
  assign stop_now      = stop_pending_q | stop;

  // Where to go once a frame (and its gap) is finished. In GAP the base has
  // already been advanced; at a zero-gap frame end it is advanced here.
  always_comb begin
    adv_base  = (state_q == GAP) ? base_q : base_plus_len;
    adv_state = DONE;
    adv_idx   = idx_q;
    adv_addr  = adv_base;
    if (next_found) begin
      adv_state = FETCH;
      adv_idx   = next_idx;
    end else if (repeat_q && wrap_found) begin
      adv_state = FETCH;
      adv_idx   = wrap_idx;
      adv_addr  = '0;
    end
  end

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    state_d        = state_q;
    idx_d          = idx_q;
    base_d         = base_q;
    rd_addr_d      = rd_addr_q;
    beats_left_d   = beats_left_q;
    nframes_d      = nframes_q;
    gap_d          = gap_q;
    gap_cnt_d      = gap_cnt_q;
    repeat_d       = repeat_q;
    stop_pending_d = stop_pending_q;
    frame_cnt_d    = frame_cnt_q;
    rd_en          = 1'b0;
    frame_end      = 1'b0;
    tvalid         = 1'b0;
    tlast          = 1'b0;
    tdata          = 8'h00;
`ifdef FRAME_CRC_EN
    crc_d          = crc_q;
    fcs_idx_d      = fcs_idx_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          nframes_d      = nframes;
          gap_d          = gap;
          repeat_d       = repeat_en;
          stop_pending_d = stop;    // start wins, but a coincident stop still counts
          base_d         = '0;
          rd_addr_d      = '0;
          idx_d          = wrap_idx;
          state_d        = wrap_found ? FETCH : DONE;
        end
      end

      FETCH: begin
        rd_en        = 1'b1;
        rd_addr_d    = rd_addr_q + 1'b1;
        beats_left_d = cur_len - 1'b1;
        state_d      = SEND;
`ifdef FRAME_CRC_EN
        crc_d        = CRC32_INIT;
`endif
      end

      SEND: begin
        tvalid = 1'b1;
        tdata  = rdata_q;
`ifndef FRAME_CRC_EN
        tlast  = (beats_left_q == '0);
`endif
        if (tready) begin
`ifdef FRAME_CRC_EN
          crc_d = crc_next;
`endif
          if (beats_left_q != '0) begin
            // Read the next byte on the same edge this one leaves, so the
            // stream has no bubble while the sink keeps tready high.
            rd_en        = 1'b1;
            rd_addr_d    = rd_addr_q + 1'b1;
            beats_left_d = beats_left_q - 1'b1;
          end else begin
`ifdef FRAME_CRC_EN
            state_d   = FCS;
            fcs_idx_d = '0;
`else
            frame_end = 1'b1;
`endif
          end
        end
      end

`ifdef FRAME_CRC_EN
      FCS: begin
        tvalid = 1'b1;
        tdata  = fcs_byte;
        tlast  = (fcs_idx_q == 2'd3);
        if (tready) begin
          if (fcs_idx_q == 2'd3) frame_end = 1'b1;
          else                   fcs_idx_d = fcs_idx_q + 1'b1;
        end
      end
`endif

      GAP: begin
        if (stop_now) begin
          state_d = DONE;
        end else if (gap_cnt_q == '0) begin
          state_d   = adv_state;
          idx_d     = adv_idx;
          base_d    = adv_addr;
          rd_addr_d = adv_addr;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d        = IDLE;
        stop_pending_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase

    if (stop && (state_q inside {FETCH, SEND, FCS, GAP})) stop_pending_d = 1'b1;

    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
      base_d      = base_plus_len;
      if (stop_now) begin
        state_d = DONE;
      end else if (gap_q != '0) begin
        state_d   = GAP;
        gap_cnt_d = gap_q - 1'b1;
      end else begin
        state_d   = adv_state;
        idx_d     = adv_idx;
        base_d    = adv_addr;
        rd_addr_d = adv_addr;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      base_q         <= '0;
      rd_addr_q      <= '0;
      beats_left_q   <= '0;
      nframes_q      <= '0;
      gap_q          <= '0;
      gap_cnt_q      <= '0;
      repeat_q       <= 1'b0;
      stop_pending_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      base_q         <= base_d;
      rd_addr_q      <= rd_addr_d;
      beats_left_q   <= beats_left_d;
      nframes_q      <= nframes_d;
      gap_q          <= gap_d;
      gap_cnt_q      <= gap_cnt_d;
      repeat_q       <= repeat_d;
      stop_pending_q <= stop_pending_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

`ifdef FRAME_CRC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q     <= CRC32_INIT;
      fcs_idx_q <= '0;
    end else begin
      crc_q     <= crc_d;
      fcs_idx_q <= fcs_idx_d;
    end
  end
`endif

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_stream_player.sv
// -----------------------------------------------------------------------------
// tb_frame_stream_player
// Directed bench for frame_stream_player. Stimulus pushes the expected
// {tlast, tdata} beats into a queue; a negedge monitor pops and compares every
// accepted beat. Timing, counters and handshake behaviour are checked inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_stream_player;

  localparam int DEPTH  = 1024;
  localparam int NFRAME = 16;
  localparam int LENW   = 11;
  localparam int GAPW   = 8;
`ifdef FRAME_CRC_EN
  localparam int FCS_N  = 4;
`else
  localparam int FCS_N  = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        buf_we = 1'b0;
  logic [9:0]  buf_addr = '0;
  logic [7:0]  buf_wdata = '0;
  logic        len_we = 1'b0;
  logic [3:0]  len_idx = '0;
  logic [10:0] len_wdata = '0;
  logic [4:0]  nframes = '0;
  logic [7:0]  gap = '0;
  logic        repeat_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tready = 1'b1;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        busy;
  logic        done;
  logic [31:0] frame_cnt;

  always #5 clk = ~clk;

  frame_stream_player #(
    .DEPTH  (DEPTH),
    .NFRAME (NFRAME),
    .LENW   (LENW),
    .GAPW   (GAPW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_wdata (buf_wdata),
    .len_we    (len_we),
    .len_idx   (len_idx),
    .len_wdata (len_wdata),
    .nframes   (nframes),
    .gap       (gap),
    .repeat_en (repeat_en),
    .start     (start),
    .stop      (stop),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tready    (tready),
    .tlast     (tlast),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [8:0] exp_q [$];
  logic [7:0] shadow [DEPTH];
  logic [8:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Scoreboard monitor: every accepted beat must match the next expected one.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got tlast=%0b tdata=0x%02h, want no beat", tlast, tdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat", {23'd0, tlast, tdata}, {23'd0, mon_e});
      end
    end
  end

`ifdef FRAME_CRC_EN
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_buf(input int a, input logic [7:0] d);
    buf_we    = 1'b1;
    buf_addr  = 10'(a);
    buf_wdata = d;
    shadow[a] = d;
    tick();
    buf_we    = 1'b0;
  endtask

  task automatic write_len(input int i, input int l);
    len_we    = 1'b1;
    len_idx   = 4'(i);
    len_wdata = 11'(l);
    tick();
    len_we    = 1'b0;
  endtask

  task automatic push_frame(input int base, input int len);
`ifdef FRAME_CRC_EN
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
`endif
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(FCS_N == 0) && (i == len - 1), shadow[(base + i) % DEPTH]});
`ifdef FRAME_CRC_EN
      c = crc_model(c, shadow[(base + i) % DEPTH]);
`endif
    end
`ifdef FRAME_CRC_EN
    c = ~c;
    for (int j = 0; j < 4; j++) exp_q.push_back({j == 3, c[8*j +: 8]});
`endif
  endtask

  task automatic start_pass(input int nf, input int g, input logic rep, input logic stp);
    nframes   = 5'(nf);
    gap       = 8'(g);
    repeat_en = rep;
    start     = 1'b1;
    stop      = stp;
    tick();
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (tvalid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({name, "_valid_seen"}, tvalid, 1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, done, 1);
    tick();
    check({name, "_done_pulse"}, done, 0);
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, idle, xfers, beats, n, ph;
    logic [7:0] held;
    logic stalled;
    logic [3:0] pat;

    tick();
    do_reset();

    // Test 1: "ABC", latency, back-to-back bytes, tlast, done timing.
    write_buf(0, 8'h41);
    write_buf(1, 8'h42);
    write_buf(2, 8'h43);
    write_len(0, 3);
    tready = 1'b1;
    push_frame(0, 3);
    start_pass(1, 0, 1'b0, 1'b0);
    check("t1_busy_after_start", busy, 1);
    check("t1_fetch_no_valid", tvalid, 0);
    tick();
    check("t1_latency_valid", tvalid, 1);
    check("t1_first_byte", tdata, 32'h41);
    nb = 3 + FCS_N;
    for (int i = 0; i < nb; i++) begin
      check("t1_stream_valid", tvalid, 1);
      check("t1_tlast_pos", tlast, (i == nb - 1) ? 1 : 0);
      tick();
    end
    check("t1_done_after_tlast", done, 1);
    tick();
    check("t1_done_one_cycle", done, 0);
    check("t1_idle", busy, 0);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_sb_empty", exp_q.size(), 0);

    // Test 2: len={2,0,1}, gap=5; empty frame skipped without extra cycles.
    do_reset();
    write_buf(0, 8'h11);
    write_buf(1, 8'h22);
    write_buf(2, 8'h33);
    write_len(0, 2);
    write_len(1, 0);
    write_len(2, 1);
    push_frame(0, 2);
    push_frame(2, 1);
    start_pass(3, 5, 1'b0, 1'b0);
    n = 0;
    while (!(tvalid && tlast) && n < 200) begin
      tick();
      n++;
    end
    check("t2_frame0_tlast_seen", tvalid && tlast, 1);
    tick();
    idle = 0;
    while (!tvalid && idle < 50) begin
      idle++;
      tick();
    end
    check("t2_idle_cycles", idle, 6);
    check("t2_frame2_byte", tdata, 32'h33);
    wait_done("t2");
    check("t2_frame_cnt", frame_cnt, 2);
    check("t2_sb_empty", exp_q.size(), 0);

    // Test 3: tready pattern 1,0,0,1 repeating; data held stable during stalls.
    do_reset();
    write_buf(0, 8'hA0);
    write_buf(1, 8'hA1);
    write_buf(2, 8'hA2);
    write_buf(3, 8'hA3);
    write_len(0, 4);
    push_frame(0, 4);
    start_pass(1, 0, 1'b0, 1'b0);
    pat     = 4'b1001;
    ph      = 0;
    xfers   = 0;
    stalled = 1'b0;
    held    = '0;
    n       = 0;
    while (done !== 1'b1 && n < 200) begin
      if (stalled) begin
        check("t3_stall_valid", tvalid, 1);
        check("t3_stall_data", tdata, {24'd0, held});
      end
      if (tvalid) begin
        tready = pat[ph % 4];
        ph++;
      end else begin
        tready = 1'b1;
      end
      stalled = tvalid && !tready;
      held    = tdata;
      if (tvalid && tready) xfers++;
      tick();
      n++;
    end
    tready = 1'b1;
    check("t3_done_seen", done, 1);
    check("t3_transfers", xfers, 4 + FCS_N);
    check("t3_frame_cnt", frame_cnt, 1);
    check("t3_sb_empty", exp_q.size(), 0);

    // Test 4: repeat with stop during the 2nd byte of pass 3.
    do_reset();
    write_buf(0, 8'h61);
    write_buf(1, 8'h62);
    write_buf(2, 8'h63);
    write_len(0, 3);
    for (int p = 0; p < 3; p++) push_frame(0, 3);
    start_pass(1, 2, 1'b1, 1'b0);
    beats = 0;
    n     = 0;
    while (done !== 1'b1 && n < 500) begin
      stop = 1'b0;
      if (tvalid) begin
        if (beats == 2 * (3 + FCS_N) + 1) stop = 1'b1;
        beats++;
      end
      tick();
      n++;
    end
    stop = 1'b0;
    check("t4_done_seen", done, 1);
    tick();
    check("t4_done_pulse", done, 0);
    check("t4_beats", beats, 3 * (3 + FCS_N));
    check("t4_frame_cnt", frame_cnt, 3);
    check("t4_sb_empty", exp_q.size(), 0);

    // Test 5: start and stop together with repeat; exactly one frame.
    do_reset();
    write_buf(3, 8'h64);
    write_buf(4, 8'h65);
    write_len(1, 2);
    push_frame(0, 3);
    start_pass(2, 0, 1'b1, 1'b1);
    beats = 0;
    n     = 0;
    while (done !== 1'b1 && n < 200) begin
      if (tvalid) beats++;
      tick();
      n++;
    end
    check("t5_done_seen", done, 1);
    check("t5_beats", beats, 3 + FCS_N);
    check("t5_frame_cnt", frame_cnt, 1);
    check("t5_sb_empty", exp_q.size(), 0);
    tick();

    // Test 6: reset during the 2nd byte of a 5-byte frame, then replay.
    for (int i = 0; i < 5; i++) write_buf(i, 8'(8'h51 + i));
    write_len(0, 5);
    push_frame(0, 5);
    start_pass(1, 0, 1'b0, 1'b0);
    wait_valid("t6");
    tick();
    check("t6_second_byte", tdata, 32'h52);
    rst = 1'b1;
    #1;
    check("t6_rst_tvalid", tvalid, 0);
    check("t6_rst_tlast", tlast, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    push_frame(0, 5);
    start_pass(1, 0, 1'b0, 1'b0);
    tick();
    check("t6_replay_first", tdata, 32'h51);
    wait_done("t6");
    check("t6_frame_cnt", frame_cnt, 1);
    check("t6_sb_empty", exp_q.size(), 0);

`ifdef FRAME_CRC_EN
    // Test 7: "123456789" gains FCS 26 39 F4 CB (CRC 0xCBF43926).
    do_reset();
    for (int i = 0; i < 9; i++) write_buf(i, 8'(8'h31 + i));
    write_len(0, 9);
    for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, 8'(8'h31 + i)});
    exp_q.push_back({1'b0, 8'h26});
    exp_q.push_back({1'b0, 8'h39});
    exp_q.push_back({1'b0, 8'hF4});
    exp_q.push_back({1'b1, 8'hCB});
    start_pass(1, 0, 1'b0, 1'b0);
    wait_done("t7");
    check("t7_frame_cnt", frame_cnt, 1);
    check("t7_sb_empty", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
